// File: rtl/regfile_sb_pkg.sv
// Shared register-file constants for the decoder, hazard unit and register file.
// Latency: n/a (constants only).
// Backpressure: n/a.
package regfile_sb_pkg;

  // Default datapath geometry: 32 registers of 32 bits.
  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;

  // Architectural zero register; reads as 0 and never holds a producer.
  localparam int ZERO_REG_ADDR = 0;

endpackage : regfile_sb_pkg

// File: rtl/regfile_sb_rf_scoreboard.sv
// Per-register busy scoreboard: tracks in-flight producers and flags stray writebacks.
// Latency: busy/WbError update on the clock edge; Busy1/Busy2/Stall are combinational.
// Backpressure: none; Stall is advisory for the hazard unit to hold dependent issue.
module rf_scoreboard
  import regfile_sb_pkg::*;
#(
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] Read1,
  input  logic [ADDR_W-1:0] Read2,
  input  logic [ADDR_W-1:0] WriteReg,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] IssueReg,
  input  logic              IssueValid,
  output logic              Busy1,
  output logic              Busy2,
  output logic              Stall,
  output logic              WbError
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam bit ZR    = (ZERO_REG != 0);
  localparam bit BP    = (BYPASS != 0);
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG_ADDR);

  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_next;
  logic             wb_stray;

  // Next busy vector: writeback clears first so a same-register issue wins.
  always_comb begin
    busy_next = busy;
    if (RegWrite) busy_next[WriteReg] = 1'b0;
    if (IssueValid) busy_next[IssueReg] = 1'b1;
    if (ZR) busy_next[ZERO_ADDR] = 1'b0;
  end

  // A writeback is stray when its target has no outstanding producer.
  always_comb begin
    wb_stray = RegWrite && !busy[WriteReg];
    if (ZR && (WriteReg == ZERO_ADDR)) wb_stray = 1'b0;
  end

  // Busy vector and sticky error, cleared only by reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy    <= '0;
      WbError <= 1'b0;
    end else begin
      busy <= busy_next;
      if (wb_stray) WbError <= 1'b1;
    end
  end

  // Operand lookup: zero register and forwarded writebacks never stall.
  always_comb begin
    Busy1 = busy[Read1];
    Busy2 = busy[Read2];
    if (ZR && (Read1 == ZERO_ADDR)) Busy1 = 1'b0;
    if (ZR && (Read2 == ZERO_ADDR)) Busy2 = 1'b0;
    if (BP && RegWrite && (WriteReg == Read1)) Busy1 = 1'b0;
    if (BP && RegWrite && (WriteReg == Read2)) Busy2 = 1'b0;
    Stall = Busy1 || Busy2;
  end

endmodule : rf_scoreboard

// File: rtl/regfile_sb.sv
// Register file with two combinational read ports, writeback bypass and busy scoreboard.
// Latency: reads and busy lookups are zero-cycle; writes land on the clock edge.
// Backpressure: none; dependent issue is held off externally using Stall.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] Read1,
  input  logic [ADDR_W-1:0] Read2,
  output logic [DATA_W-1:0] Data1,
  output logic [DATA_W-1:0] Data2,
  input  logic [ADDR_W-1:0] WriteReg,
  input  logic [DATA_W-1:0] WriteData,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] IssueReg,
  input  logic              IssueValid,
  output logic              Busy1,
  output logic              Busy2,
  output logic              Stall,
  output logic              WbError
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam bit ZR    = (ZERO_REG != 0);
  localparam bit BP    = (BYPASS != 0);
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG_ADDR);

  logic [DATA_W-1:0] rf [DEPTH];
  logic              wr_en;

  // Writes to the hardwired zero register are dropped.
  assign wr_en = RegWrite && !(ZR && (WriteReg == ZERO_ADDR));

  // Register array: async clear, synchronous write.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) rf[i] <= '0;
    end else if (wr_en) begin
      rf[WriteReg] <= WriteData;
    end
  end

  // Read port 1: zero register beats bypass, bypass beats the array.
  always_comb begin
    Data1 = rf[Read1];
    if (BP && RegWrite && (WriteReg == Read1)) Data1 = WriteData;
    if (ZR && (Read1 == ZERO_ADDR)) Data1 = '0;
  end

  // Read port 2: same priority as port 1.
  always_comb begin
    Data2 = rf[Read2];
    if (BP && RegWrite && (WriteReg == Read2)) Data2 = WriteData;
    if (ZR && (Read2 == ZERO_ADDR)) Data2 = '0;
  end

  rf_scoreboard #(
    .ADDR_W  (ADDR_W),
    .ZERO_REG(ZERO_REG),
    .BYPASS  (BYPASS)
  ) u_scoreboard (
    .clock     (clock),
    .reset     (reset),
    .Read1     (Read1),
    .Read2     (Read2),
    .WriteReg  (WriteReg),
    .RegWrite  (RegWrite),
    .IssueReg  (IssueReg),
    .IssueValid(IssueValid),
    .Busy1     (Busy1),
    .Busy2     (Busy2),
    .Stall     (Stall),
    .WbError   (WbError)
  );

endmodule : regfile_sb

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb with a behavioural reference model.
// Latency: checks combinational outputs each cycle at the falling edge.
// Backpressure: n/a.
module tb_regfile_sb;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  Read1 = '0, Read2 = '0, WriteReg = '0, IssueReg = '0;
  logic [31:0] WriteData = '0;
  logic        RegWrite = 1'b0, IssueValid = 1'b0;
  logic [31:0] Data1, Data2;
  logic        Busy1, Busy2, Stall, WbError;

  int checks = 0;
  int errors = 0;

  regfile_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) dut (
    .clock(clock), .reset(reset),
    .Read1(Read1), .Read2(Read2), .Data1(Data1), .Data2(Data2),
    .WriteReg(WriteReg), .WriteData(WriteData), .RegWrite(RegWrite),
    .IssueReg(IssueReg), .IssueValid(IssueValid),
    .Busy1(Busy1), .Busy2(Busy2), .Stall(Stall), .WbError(WbError)
  );

  always #5 clock = ~clock;

  // Reference model: architectural register contents, producer flags, error flag.
  logic [31:0] m_rf   [32];
  bit          m_busy [32];
  bit          m_err;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        m_rf[i] = '0;
        m_busy[i] = 1'b0;
      end
      m_err = 1'b0;
    end else begin
      if (RegWrite && WriteReg != 0) begin
        if (!m_busy[WriteReg]) m_err = 1'b1;
        m_rf[WriteReg] = WriteData;
        m_busy[WriteReg] = 1'b0;
      end
      if (IssueValid && IssueReg != 0) m_busy[IssueReg] = 1'b1;
    end
  end

  function automatic logic [31:0] exp_data(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (RegWrite && WriteReg == a) return WriteData;
    return m_rf[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
    if (a == 0) return 1'b0;
    if (RegWrite && WriteReg == a) return 1'b0;
    return m_busy[a];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    chk("m_data1", Data1, exp_data(Read1));
    chk("m_data2", Data2, exp_data(Read2));
    chk("m_busy1", {31'b0, Busy1}, {31'b0, exp_busy(Read1)});
    chk("m_busy2", {31'b0, Busy2}, {31'b0, exp_busy(Read2)});
    chk("m_stall", {31'b0, Stall}, {31'b0, exp_busy(Read1) | exp_busy(Read2)});
    chk("m_wberr", {31'b0, WbError}, {31'b0, m_err});
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    RegWrite = 1'b0;
    IssueValid = 1'b0;
  endtask

  initial begin
    #2;
    chk("rst_data1", Data1, 32'h0);
    chk("rst_wberr", {31'b0, WbError}, 32'h0);
    step();
    reset = 1'b0;

    // Mid-cycle reset after R5 written and re-issued.
    IssueValid = 1'b1; IssueReg = 5'd5;
    step();
    IssueValid = 1'b0; RegWrite = 1'b1; WriteReg = 5'd5; WriteData = 32'hDEADBEEF;
    step();
    idle(); IssueValid = 1'b1; IssueReg = 5'd5;
    step();
    idle(); Read1 = 5'd5;
    #1;
    chk("pre_rst_data1", Data1, 32'hDEADBEEF);
    chk("pre_rst_busy1", {31'b0, Busy1}, 32'h1);
    #1 reset = 1'b1;
    #1;
    chk("async_rst_data1", Data1, 32'h0);
    chk("async_rst_busy1", {31'b0, Busy1}, 32'h0);
    chk("async_rst_wberr", {31'b0, WbError}, 32'h0);
    step();
    reset = 1'b0;

    // Write R7, then read it alongside R0.
    IssueValid = 1'b1; IssueReg = 5'd7;
    step();
    idle(); RegWrite = 1'b1; WriteReg = 5'd7; WriteData = 32'h12345678;
    step();
    idle(); Read1 = 5'd7; Read2 = 5'd0;
    #1;
    chk("r7_data1", Data1, 32'h12345678);
    chk("r0_data2", Data2, 32'h0);
    RegWrite = 1'b1; WriteReg = 5'd0; WriteData = 32'hFFFFFFFF;
    IssueValid = 1'b1; IssueReg = 5'd0;
    #1;
    chk("r0_nobypass", Data2, 32'h0);
    step();
    idle();
    #1;
    chk("r0_after_wr", Data2, 32'h0);
    chk("r0_busy2", {31'b0, Busy2}, 32'h0);
    chk("r0_wberr", {31'b0, WbError}, 32'h0);

    // Same-cycle bypass on R3.
    IssueValid = 1'b1; IssueReg = 5'd3;
    step();
    idle(); RegWrite = 1'b1; WriteReg = 5'd3; WriteData = 32'hA5A5A5A5; Read1 = 5'd3;
    #1;
    chk("byp_data1", Data1, 32'hA5A5A5A5);
    chk("byp_busy1", {31'b0, Busy1}, 32'h0);
    step();
    idle();

    // Issue R9, observe stall, then bypassed writeback.
    IssueValid = 1'b1; IssueReg = 5'd9;
    step();
    idle(); Read2 = 5'd9;
    #1;
    chk("r9_busy2", {31'b0, Busy2}, 32'h1);
    chk("r9_stall", {31'b0, Stall}, 32'h1);
    RegWrite = 1'b1; WriteReg = 5'd9; WriteData = 32'h55;
    #1;
    chk("r9_wb_busy2", {31'b0, Busy2}, 32'h0);
    chk("r9_wb_data2", Data2, 32'h55);
    step();
    idle();
    #1;
    chk("r9_post_busy2", {31'b0, Busy2}, 32'h0);
    chk("r9_post_data2", Data2, 32'h55);

    // Issue and writeback to busy R4 in the same cycle: new producer wins.
    IssueValid = 1'b1; IssueReg = 5'd4;
    step();
    RegWrite = 1'b1; WriteReg = 5'd4; WriteData = 32'h44; Read1 = 5'd4;
    step();
    idle();
    #1;
    chk("r4_busy1", {31'b0, Busy1}, 32'h1);
    chk("r4_data1", Data1, 32'h44);
    chk("r4_wberr", {31'b0, WbError}, 32'h0);
    IssueValid = 1'b1; IssueReg = 5'd4;
    step();
    idle();
    #1;
    chk("r4_reissue_busy1", {31'b0, Busy1}, 32'h1);
    chk("r4_reissue_wberr", {31'b0, WbError}, 32'h0);

    // Stray writeback to R12 sets the sticky error.
    RegWrite = 1'b1; WriteReg = 5'd12; WriteData = 32'h12;
    step();
    idle();
    #1;
    chk("r12_wberr", {31'b0, WbError}, 32'h1);
    step();
    step();
    chk("r12_wberr_sticky", {31'b0, WbError}, 32'h1);
    reset = 1'b1;
    #1;
    chk("r12_wberr_rst", {31'b0, WbError}, 32'h0);
    step();
    reset = 1'b0;
    step();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_regfile_sb

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the team's single-cycle 32x32 register file, for the pipelined datapath.
- Generalised data width and depth, synchronous write, and two combinational read ports.
- Adds asynchronous clear, hardwired zero register, write-to-read bypass, and a per-register scoreboard.
- The scoreboard tracks in-flight producers so the hazard unit can stall dependent instructions.

Parameters:
- DATA_W, 32, data word width in bits.
- ADDR_W, 5, register address width; depth = 2**ADDR_W.
- ZERO_REG, 1, when 1 register 0 reads as 0, ignores writes and is never marked busy.
- BYPASS, 1, when 1 a same-cycle write is forwarded to the read ports and to the busy check.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; clears the register array, busy bits and WbError.
- Read1  in  ADDR_W  read port 1 address.
- Read2  in  ADDR_W  read port 2 address.
- Data1  out  DATA_W  read port 1 data, combinational.
- Data2  out  DATA_W  read port 2 data, combinational.
- WriteReg  in  ADDR_W  writeback destination.
- WriteData  in  DATA_W  writeback data.
- RegWrite  in  1  writeback enable.
- IssueReg  in  ADDR_W  destination of the instruction issuing this cycle.
- IssueValid  in  1  issue enable; marks IssueReg busy.
- Busy1  out  1  Read1 has an outstanding producer.
- Busy2  out  1  Read2 has an outstanding producer.
- Stall  out  1  Busy1 OR Busy2.
- WbError  out  1  sticky: a writeback hit a register that was not busy.

Behaviour:
- Reset (async, any time, including mid-operation): all RF entries = 0, all busy bits = 0, WbError = 0. Outputs settle combinationally: Data = 0, Busy = 0, Stall = 0. The first edge after reset deassertion is a normal cycle.
- Write: on posedge clock when RegWrite=1, RF[WriteReg] <= WriteData. If ZERO_REG=1 and WriteReg=0, no write occurs.
- Read, per port n: DataN = 0 if ZERO_REG and ReadN=0.
- Otherwise, if BYPASS and RegWrite and WriteReg=ReadN: DataN = WriteData.
- Otherwise DataN = RF[ReadN]. Zero latency.
- Scoreboard state: busy[DEPTH-1:0], updated on posedge clock.
- Writeback (RegWrite) clears busy[WriteReg].
- Issue (IssueValid) sets busy[IssueReg].
- Issue and writeback to the same register in the same cycle: busy ends SET (the new producer wins).
- Issue and writeback to different registers: both updates apply.
- ZERO_REG=1: issue or writeback to register 0 leaves busy[0] = 0.
- BusyN = busy[ReadN], forced 0 when ZERO_REG and ReadN=0.
- BYPASS=1: BusyN is also forced 0 when RegWrite and WriteReg=ReadN (the data is forwarded this cycle).
- Stall is combinational from Busy1 and Busy2.
- WbError: set on posedge when RegWrite=1, busy[WriteReg]=0, and WriteReg is not the exempt zero register. Cleared only by reset.
- Reissue to an already-busy register: busy stays 1; no error.

Decomposition:
- Shared package: DATA_W/ADDR_W defaults and the ZERO_REG_ADDR constant, reused by the decoder and hazard unit.
- One natural sub-module: rf_scoreboard, holding the busy vector, its set/clear priority, WbError, and the Busy1/Busy2 lookup with bypass masking.
- The register array and read muxes stay in the top level.

Test Plan:
- Assert reset mid-cycle after writing R5=0xDEADBEEF -> Data1=0 immediately with Read1=5, Busy1=0, WbError=0, no clock edge required.
- Write R7=0x12345678, next cycle Read1=7 and Read2=0 -> Data1=0x12345678, Data2=0. Then write R0=0xFFFFFFFF -> Data2 still 0.
- BYPASS=1: RegWrite, WriteReg=3, WriteData=0xA5A5A5A5, Read1=3 in the same cycle -> Data1=0xA5A5A5A5 before the edge, Busy1=0.
- IssueValid with IssueReg=9; next cycle Read2=9 -> Busy2=1, Stall=1. Writeback R9=0x55 -> Busy2=0 in that cycle (bypass) and stays 0 after the edge.
- Issue IssueReg=4 and writeback WriteReg=4 in the same cycle, with R4 previously busy -> after the edge Busy1=1 for Read1=4 and WbError=0.
- Writeback to R12 when never issued -> WbError=1 after the edge, remaining 1 until reset. Repeat with ZERO_REG=1 and WriteReg=0 -> WbError stays 0.
